// File: rtl/chunked_addsub_if.sv
`default_nettype none
// ============================================================================
// Module   : chunked_addsub_if
// Purpose  : Operand/result handshake bundle for the chunked adder/subtractor.
// Revision : 1.0 - initial release
// ============================================================================
interface chunked_addsub_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             carryout;
    logic             overflow;

    modport master (
        output in_valid, a, b, sub, out_ready,
        input  in_ready, out_valid, sum, carryout, overflow
    );

    modport slave (
        input  in_valid, a, b, sub, out_ready,
        output in_ready, out_valid, sum, carryout, overflow
    );
endinterface
`default_nettype wire

// File: rtl/chunked_addsub.sv
`default_nettype none
// ============================================================================
// Module   : chunked_addsub
// Purpose  : Multi-cycle two's-complement add/subtract, CHUNK bits per clock.
// Revision : 1.0 - initial release
// ============================================================================
module chunked_addsub #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             reset,
    chunked_addsub_if.slave  bus
);
    localparam int              c_N    = WIDTH / CHUNK;
    localparam int              c_CW   = (c_N > 1) ? $clog2(c_N) : 1;
    localparam logic [c_CW-1:0] c_LAST = c_CW'(c_N - 1);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_RUN  = 2'd1;
    localparam logic [1:0] c_ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        IDLE = c_ST_IDLE,
        RUN  = c_ST_RUN,
        DONE = c_ST_DONE
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_a_msb;
    logic             r_b_msb;
    logic             r_carry;
    logic [c_CW-1:0]  r_cnt;
    logic [WIDTH-1:0] r_sum;
    logic             r_carryout;
    logic             r_overflow;

    logic [CHUNK:0]   w_chunk;
    logic [WIDTH-1:0] w_sum_next;
    logic [WIDTH-1:0] w_a_shift;
    logic [WIDTH-1:0] w_b_shift;
    logic             w_ovf;

    // Operands shift down so the active chunk is always in the low bits;
    // result chunks enter at the top and settle in place after N shifts.
    assign w_chunk = {1'b0, r_a[CHUNK-1:0]} + {1'b0, r_b[CHUNK-1:0]}
                   + {{CHUNK{1'b0}}, r_carry};

    generate
        if (CHUNK == WIDTH) begin : g_single
            assign w_sum_next = w_chunk[CHUNK-1:0];
            assign w_a_shift  = r_a;
            assign w_b_shift  = r_b;
        end else begin : g_multi
            assign w_sum_next = {w_chunk[CHUNK-1:0], r_sum[WIDTH-1:CHUNK]};
            assign w_a_shift  = {{CHUNK{1'b0}}, r_a[WIDTH-1:CHUNK]};
            assign w_b_shift  = {{CHUNK{1'b0}}, r_b[WIDTH-1:CHUNK]};
        end
    endgenerate

    // The last chunk's top bit is the result sign bit.
    assign w_ovf = (r_a_msb == r_b_msb) && (w_chunk[CHUNK-1] != r_b_msb);

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (bus.in_valid)     w_state_next = RUN;
            RUN:     if (r_cnt == c_LAST)  w_state_next = DONE;
            DONE:    if (bus.out_ready)    w_state_next = IDLE;
            default:                       w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_a        <= '0;
            r_b        <= '0;
            r_a_msb    <= 1'b0;
            r_b_msb    <= 1'b0;
            r_carry    <= 1'b0;
            r_cnt      <= '0;
            r_sum      <= '0;
            r_carryout <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_state <= w_state_next;
            case (r_state)
                IDLE: begin
                    if (bus.in_valid) begin
                        r_a     <= bus.a;
                        r_b     <= bus.sub ? ~bus.b : bus.b;
                        r_a_msb <= bus.a[WIDTH-1];
                        r_b_msb <= bus.sub ^ bus.b[WIDTH-1];
                        r_carry <= bus.sub;
                        r_cnt   <= '0;
                    end
                end
                RUN: begin
                    r_a     <= w_a_shift;
                    r_b     <= w_b_shift;
                    r_sum   <= w_sum_next;
                    r_carry <= w_chunk[CHUNK];
                    r_cnt   <= r_cnt + c_CW'(1);
                    if (r_cnt == c_LAST) begin
                        r_carryout <= w_chunk[CHUNK];
                        r_overflow <= w_ovf;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.in_ready  = (r_state == IDLE);
    assign bus.out_valid = (r_state == DONE);
    assign bus.sum       = r_sum;
    assign bus.carryout  = r_carryout;
    assign bus.overflow  = r_overflow;
endmodule
`default_nettype wire

// File: tb/tb_chunked_addsub.sv
`default_nettype none
// ============================================================================
// Module   : tb_chunked_addsub
// Purpose  : Self-checking bench for chunked_addsub at 32/4, 8/4 and 8/8.
// Revision : 1.0 - initial release
// ============================================================================
module tb_chunked_addsub;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    chunked_addsub_if #(.WIDTH(32)) bus0 ();
    chunked_addsub_if #(.WIDTH(8))  bus1 ();
    chunked_addsub_if #(.WIDTH(8))  bus2 ();

    chunked_addsub #(.WIDTH(32), .CHUNK(4)) u_w32c4 (.clk(clk), .reset(reset), .bus(bus0));
    chunked_addsub #(.WIDTH(8),  .CHUNK(4)) u_w8c4  (.clk(clk), .reset(reset), .bus(bus1));
    chunked_addsub #(.WIDTH(8),  .CHUNK(8)) u_w8c8  (.clk(clk), .reset(reset), .bus(bus2));

    typedef struct {
        int          dut;
        logic [31:0] a;
        logic [31:0] b;
        logic        sub;
        logic [31:0] sum;
        logic        co;
        logic        ov;
    } vec_t;

    typedef struct {
        logic [31:0] sum;
        logic        co;
        logic        ov;
        int          lat;
    } exp_t;

    exp_t sb[$];
    vec_t tbl[12];
    int   n_run  = 0;
    int   n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int nchunks(input int d);
        return (d == 0) ? 8 : (d == 1) ? 2 : 1;
    endfunction

    function automatic int width(input int d);
        return (d == 0) ? 32 : 8;
    endfunction

    // Reference arithmetic: a + (sub ? ~b : b) + sub, modulo 2^w.
    function automatic exp_t model(input int d, input logic [31:0] a, input logic [31:0] b,
                                   input logic sub);
        exp_t        e;
        int          w;
        logic [31:0] mask;
        logic [31:0] aa;
        logic [31:0] bb;
        logic [32:0] t;
        w    = width(d);
        mask = (w == 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
        aa   = a & mask;
        bb   = (sub ? ~b : b) & mask;
        t    = {1'b0, aa} + {1'b0, bb} + {32'h0, sub};
        e.sum = t[31:0] & mask;
        e.co  = t[w];
        e.ov  = (aa[w-1] == bb[w-1]) && (e.sum[w-1] != bb[w-1]);
        e.lat = nchunks(d);
        return e;
    endfunction

    task automatic drive(input int d, input logic iv, input logic [31:0] a, input logic [31:0] b,
                         input logic sub, input logic ordy);
        case (d)
            0: begin bus0.in_valid = iv; bus0.a = a;      bus0.b = b;      bus0.sub = sub; bus0.out_ready = ordy; end
            1: begin bus1.in_valid = iv; bus1.a = a[7:0]; bus1.b = b[7:0]; bus1.sub = sub; bus1.out_ready = ordy; end
            default: begin bus2.in_valid = iv; bus2.a = a[7:0]; bus2.b = b[7:0]; bus2.sub = sub; bus2.out_ready = ordy; end
        endcase
    endtask

    task automatic sample(input int d, output logic ir, output logic ovl, output logic [31:0] s,
                          output logic co, output logic ovf);
        case (d)
            0: begin ir = bus0.in_ready; ovl = bus0.out_valid; s = bus0.sum; co = bus0.carryout; ovf = bus0.overflow; end
            1: begin ir = bus1.in_ready; ovl = bus1.out_valid; s = {24'h0, bus1.sum}; co = bus1.carryout; ovf = bus1.overflow; end
            default: begin ir = bus2.in_ready; ovl = bus2.out_valid; s = {24'h0, bus2.sum}; co = bus2.carryout; ovf = bus2.overflow; end
        endcase
    endtask

    // Waits for out_valid after an accept edge; returns edges elapsed.
    task automatic wait_result(input int d, input string name, output int lat);
        logic ir, ovl, co, ovf;
        logic [31:0] s;
        lat = 0;
        forever begin
            @(negedge clk);
            sample(d, ir, ovl, s, co, ovf);
            if (ovl) break;
            if (lat > 50) begin
                check({name, " timeout"}, 32'd0, 32'd1);
                break;
            end
            @(posedge clk);
            lat++;
        end
    endtask

    task automatic compare_out(input int d, input string name, input int lat);
        logic ir, ovl, co, ovf;
        logic [31:0] s;
        exp_t e;
        sample(d, ir, ovl, s, co, ovf);
        if (sb.size() == 0) begin
            check({name, " scoreboard empty"}, 32'd0, 32'd1);
            return;
        end
        e = sb.pop_front();
        check({name, " sum"},      s,           e.sum);
        check({name, " carryout"}, {31'h0, co}, {31'h0, e.co});
        check({name, " overflow"}, {31'h0, ovf}, {31'h0, e.ov});
        check({name, " latency"},  lat,         e.lat);
        check({name, " in_ready in DONE"}, {31'h0, ir}, 32'd0);
    endtask

    task automatic run_op(input int d, input logic [31:0] a, input logic [31:0] b, input logic sub,
                          input logic [31:0] esum, input logic eco, input logic eov, input string name);
        logic ir, ovl, co, ovf;
        logic [31:0] s;
        int   lat;
        exp_t e;
        @(negedge clk);
        drive(d, 1'b1, a, b, sub, 1'b0);
        sample(d, ir, ovl, s, co, ovf);
        check({name, " in_ready before accept"}, {31'h0, ir}, 32'd1);
        @(posedge clk);
        e.sum = esum; e.co = eco; e.ov = eov; e.lat = nchunks(d);
        sb.push_back(e);
        #1 drive(d, 1'b0, ~a, ~b, ~sub, 1'b0);
        wait_result(d, name, lat);
        compare_out(d, name, lat);
        drive(d, 1'b0, ~a, ~b, ~sub, 1'b1);
        @(posedge clk);
        @(negedge clk);
        sample(d, ir, ovl, s, co, ovf);
        check({name, " in_ready after handshake"}, {31'h0, ir}, 32'd1);
        check({name, " out_valid after handshake"}, {31'h0, ovl}, 32'd0);
        drive(d, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got running expected done");
        $fatal(1);
    end

    initial begin
        logic ir, ovl, co, ovf;
        logic [31:0] s;
        logic [31:0] ra, rb;
        logic        rs;
        exp_t        e;
        int          lat;
        int          pulses;

        tbl[0]  = '{1, 32'hFF,        32'h01,        1'b0, 32'h00,        1'b1, 1'b0};
        tbl[1]  = '{1, 32'h7F,        32'h01,        1'b0, 32'h80,        1'b0, 1'b1};
        tbl[2]  = '{1, 32'h80,        32'h80,        1'b0, 32'h00,        1'b1, 1'b1};
        tbl[3]  = '{1, 32'h00,        32'h80,        1'b1, 32'h80,        1'b0, 1'b1};
        tbl[4]  = '{0, 32'd5,         32'd7,         1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0};
        tbl[5]  = '{0, 32'h0,         32'h8000_0000, 1'b1, 32'h8000_0000, 1'b0, 1'b1};
        tbl[6]  = '{0, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 32'hACF1_3568, 1'b0, 1'b0};
        tbl[7]  = '{0, 32'h7FFF_FFFF, 32'h1,         1'b0, 32'h8000_0000, 1'b0, 1'b1};
        tbl[8]  = '{0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'h0,         1'b1, 1'b0};
        tbl[9]  = '{2, 32'h7F,        32'h01,        1'b0, 32'h80,        1'b0, 1'b1};
        tbl[10] = '{2, 32'h10,        32'h20,        1'b1, 32'hF0,        1'b0, 1'b0};
        tbl[11] = '{2, 32'h80,        32'h01,        1'b1, 32'h7F,        1'b1, 1'b1};

        for (int d = 0; d < 3; d++) drive(d, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            sample(d, ir, ovl, s, co, ovf);
            check($sformatf("reset dut%0d in_ready", d),  {31'h0, ir},  32'd1);
            check($sformatf("reset dut%0d out_valid", d), {31'h0, ovl}, 32'd0);
            check($sformatf("reset dut%0d sum", d),       s,            32'd0);
            check($sformatf("reset dut%0d carryout", d),  {31'h0, co},  32'd0);
            check($sformatf("reset dut%0d overflow", d),  {31'h0, ovf}, 32'd0);
        end

        for (int i = 0; i < 12; i++)
            run_op(tbl[i].dut, tbl[i].a, tbl[i].b, tbl[i].sub,
                   tbl[i].sum, tbl[i].co, tbl[i].ov, $sformatf("vec%0d", i));

        for (int i = 0; i < 8; i++) begin
            int d;
            d  = (i % 2 == 0) ? 0 : 2;
            ra = $urandom;
            rb = $urandom;
            rs = 1'($urandom_range(0, 1));
            if (d != 0) begin ra = ra & 32'hFF; rb = rb & 32'hFF; end
            e = model(d, ra, rb, rs);
            run_op(d, ra, rb, rs, e.sum, e.co, e.ov, $sformatf("rand%0d", i));
        end

        // Backpressure, then back-to-back with in_valid and out_ready held.
        @(negedge clk);
        drive(0, 1'b1, 32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0);
        @(posedge clk);
        #1 drive(0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        wait_result(0, "bp", lat);
        check("bp latency", lat, 32'd8);
        for (int k = 0; k < 5; k++) begin
            sample(0, ir, ovl, s, co, ovf);
            check($sformatf("bp hold%0d sum", k),       s,            32'h2345_6789);
            check($sformatf("bp hold%0d out_valid", k), {31'h0, ovl}, 32'd1);
            check($sformatf("bp hold%0d in_ready", k),  {31'h0, ir},  32'd0);
            check($sformatf("bp hold%0d flags", k),     {30'h0, co, ovf}, 32'd0);
            @(negedge clk);
        end
        drive(0, 1'b1, 32'd100, 32'd58, 1'b1, 1'b1);
        @(posedge clk);
        @(negedge clk);
        sample(0, ir, ovl, s, co, ovf);
        check("b2b in_ready after handshake",  {31'h0, ir},  32'd1);
        check("b2b out_valid after handshake", {31'h0, ovl}, 32'd0);
        @(posedge clk);
        e.sum = 32'd42; e.co = 1'b1; e.ov = 1'b0; e.lat = 8;
        sb.push_back(e);
        #1 drive(0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        wait_result(0, "b2b", lat);
        compare_out(0, "b2b", lat);
        @(posedge clk);
        @(negedge clk);
        sample(0, ir, ovl, s, co, ovf);
        check("b2b in_ready after second handshake", {31'h0, ir}, 32'd1);
        drive(0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

        // Reset while chunk 3 is pending.
        @(negedge clk);
        drive(0, 1'b1, 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b1);
        @(posedge clk);
        #1 drive(0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        sample(0, ir, ovl, s, co, ovf);
        check("midrun reset in_ready",  {31'h0, ir},  32'd1);
        check("midrun reset out_valid", {31'h0, ovl}, 32'd0);
        check("midrun reset sum",       s,            32'd0);
        check("midrun reset flags",     {30'h0, co, ovf}, 32'd0);
        pulses = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            sample(0, ir, ovl, s, co, ovf);
            if (ovl) pulses++;
        end
        check("midrun reset no out_valid pulse", pulses, 32'd0);
        drive(0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        run_op(0, 32'd1, 32'd2, 1'b0, 32'd3, 1'b0, 1'b0, "post reset add");

        check("scoreboard drained", sb.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
